// File: rtl/alu_wb_buffer_pkg.sv
// Shared types for the ALU-to-writeback result buffer.
// XLEN and TRANS_ID_BITS mirror the core-wide riscv/ariane package values.
package alu_wb_buffer_pkg;

   localparam int XLEN          = 64;
   localparam int TRANS_ID_BITS = 3;

   typedef logic [XLEN-1:0] xlen_t;

   // One buffered ALU result; the three fields always travel together.
   typedef struct packed {
      xlen_t                    result;
      logic                     branch_res;
      logic [TRANS_ID_BITS-1:0] trans_id;
   } alu_wb_t;

endpackage

// File: rtl/alu_wb_buffer.sv
// Small FIFO between the ALU and the scoreboard writeback port.
// It decouples ALU issue from writeback back-pressure with one cycle of
// latency. Ready and valid come only from registered occupancy, so there
// is no combinational path from alu_* to wb_*, or from wb_ready_i to
// alu_ready_o.
module alu_wb_buffer
   import alu_wb_buffer_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       alu_valid_i,
   output logic                       alu_ready_o,
   input  logic [XLEN-1:0]            alu_result_i,
   input  logic                       alu_branch_res_i,
   input  logic [TRANS_ID_BITS-1:0]   alu_trans_id_i,
   output logic                       wb_valid_o,
   input  logic                       wb_ready_i,
   output logic [XLEN-1:0]            wb_result_o,
   output logic                       wb_branch_res_o,
   output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
   output logic [$clog2(DEPTH):0]     usage_o
);

   localparam int             PW      = $clog2(DEPTH);
   localparam int             CW      = PW + 1;
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

   alu_wb_t          mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    usage;
   logic             push;
   logic             pop;
   alu_wb_t          head;

   // Handshakes: a full buffer ignores alu_valid_i even if it pops this
   // cycle, and a flush cancels both directions.
   assign alu_ready_o = (usage < DEPTH_C);
   assign wb_valid_o  = (usage != '0);
   assign push        = alu_valid_i & alu_ready_o & ~flush_i;
   assign pop         = wb_valid_o  & wb_ready_i  & ~flush_i;

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         usage  <= '0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         usage  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   usage <= usage + CW'(1);
            2'b01:   usage <= usage - CW'(1);
            default: usage <= usage;
         endcase
      end
   end

   // Entry storage, written at the tail on each accepted push.
   // NOTE: the storage is reset on purpose so the head reads zero while in
   // reset; this keeps it as plain flops rather than an inferred RAM.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= '{result:     alu_result_i,
                          branch_res: alu_branch_res_i,
                          trans_id:   alu_trans_id_i};
      end
   end

   // The head entry is presented directly from storage.
   assign head            = mem[rd_ptr];
   assign wb_result_o     = head.result;
   assign wb_branch_res_o = head.branch_res;
   assign wb_trans_id_o   = head.trans_id;
   assign usage_o         = usage;

   // Internal push/pop must never hit a full/empty buffer.
   a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push && (usage == DEPTH_C)))
      else $error("alu_wb_buffer: push while full");

   a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(pop && (usage == '0)))
      else $error("alu_wb_buffer: pop while empty");

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Self-checking bench for alu_wb_buffer. Two instances (DEPTH 2 and 4)
// see the same stimulus; each is compared every cycle against a queue
// model of an ideal FIFO with the same capacity.
module tb_alu_wb_buffer;
   import alu_wb_buffer_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst_ni;
   logic                     flush;
   logic                     av;
   logic [XLEN-1:0]          res;
   logic                     br;
   logic [TRANS_ID_BITS-1:0] id;
   logic                     wr;

   logic                     rdy2, val2, br2, rdy4, val4, br4;
   logic [XLEN-1:0]          res2, res4;
   logic [TRANS_ID_BITS-1:0] id2, id4;
   logic [1:0]               use2;
   logic [2:0]               use4;

   int tests = 0;
   int fails = 0;

   alu_wb_t qa[$];   // model of the DEPTH=2 instance
   alu_wb_t qb[$];   // model of the DEPTH=4 instance

   always #5 clk = ~clk;

   alu_wb_buffer #(.DEPTH(2)) dut2 (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
      .alu_valid_i(av), .alu_ready_o(rdy2), .alu_result_i(res),
      .alu_branch_res_i(br), .alu_trans_id_i(id),
      .wb_valid_o(val2), .wb_ready_i(wr), .wb_result_o(res2),
      .wb_branch_res_o(br2), .wb_trans_id_o(id2), .usage_o(use2));

   alu_wb_buffer #(.DEPTH(4)) dut4 (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
      .alu_valid_i(av), .alu_ready_o(rdy4), .alu_result_i(res),
      .alu_branch_res_i(br), .alu_trans_id_i(id),
      .wb_valid_o(val4), .wb_ready_i(wr), .wb_result_o(res4),
      .wb_branch_res_o(br4), .wb_trans_id_o(id4), .usage_o(use4));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare both instances with their models (outputs depend on state only).
   task automatic check_all(input string tag);
      check({tag, " d2 usage"}, 64'(use2), 64'(qa.size()));
      check({tag, " d2 ready"}, 64'(rdy2), 64'(qa.size() < 2));
      check({tag, " d2 valid"}, 64'(val2), 64'(qa.size() != 0));
      if (qa.size() != 0) begin
         check({tag, " d2 result"}, res2, qa[0].result);
         check({tag, " d2 br"}, 64'(br2), 64'(qa[0].branch_res));
         check({tag, " d2 id"}, 64'(id2), 64'(qa[0].trans_id));
      end
      check({tag, " d4 usage"}, 64'(use4), 64'(qb.size()));
      check({tag, " d4 ready"}, 64'(rdy4), 64'(qb.size() < 4));
      check({tag, " d4 valid"}, 64'(val4), 64'(qb.size() != 0));
      if (qb.size() != 0) begin
         check({tag, " d4 result"}, res4, qb[0].result);
         check({tag, " d4 br"}, 64'(br4), 64'(qb[0].branch_res));
         check({tag, " d4 id"}, 64'(id4), 64'(qb[0].trans_id));
      end
   endtask

   // One clock: check at negedge, advance the models, then step past posedge.
   task automatic tick(input string tag);
      alu_wb_t e;
      bit      pa, pb, oa, ob;
      @(negedge clk);
      check_all(tag);
      e  = '{result: res, branch_res: br, trans_id: id};
      pa = av && (qa.size() < 2);
      pb = av && (qb.size() < 4);
      oa = wr && (qa.size() != 0);
      ob = wr && (qb.size() != 0);
      if (flush) begin
         qa.delete();
         qb.delete();
      end else begin
         if (oa) void'(qa.pop_front());
         if (ob) void'(qb.pop_front());
         if (pa) qa.push_back(e);
         if (pb) qb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " d2 usage"}, 64'(use2), 64'd0);
      check({tag, " d2 valid"}, 64'(val2), 64'd0);
      check({tag, " d2 ready"}, 64'(rdy2), 64'd1);
      check({tag, " d2 result"}, res2, 64'd0);
      check({tag, " d2 br"}, 64'(br2), 64'd0);
      check({tag, " d2 id"}, 64'(id2), 64'd0);
      check({tag, " d4 usage"}, 64'(use4), 64'd0);
      check({tag, " d4 valid"}, 64'(val4), 64'd0);
      check({tag, " d4 result"}, res4, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int accepted;
      int cycles;

      // Reset state
      rst_ni = 1'b0; flush = 1'b0; av = 1'b0; wr = 1'b0;
      res = '0; br = 1'b0; id = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst_ni = 1'b1;
      @(posedge clk);
      #1;

      // Single push with one-cycle latency, then drained
      av = 1'b1; res = 64'h0000_0000_DEAD_BEEF; br = 1'b1; id = 3; wr = 1'b1;
      tick("r031 push");
      av = 1'b0;
      check("r031 valid", 64'(val2), 64'd1);
      check("r031 result", res2, 64'h0000_0000_DEAD_BEEF);
      check("r031 id", 64'(id2), 64'd3);
      tick("r031 pop");
      tick("r031 empty");
      check("r031 usage", 64'(use2), 64'd0);

      // Fill DEPTH=2, third push dropped, release in order
      wr = 1'b0; av = 1'b1; br = 1'b0;
      id = 1; res = 64'h11; tick("r032 p1");
      id = 2; res = 64'h22; tick("r032 p2");
      check("r032 ready low", 64'(rdy2), 64'd0);
      id = 3; res = 64'h33; tick("r032 p3");
      av = 1'b0;            tick("r032 hold");
      wr = 1'b1;
      check("r032 first id", 64'(id2), 64'd1);
      tick("r032 rel1");
      check("r032 second id", 64'(id2), 64'd2);
      tick("r032 rel2");
      tick("r032 rel3");
      check("r032 drained", 64'(val2), 64'd0);

      // Full, push and pop together: pop only
      wr = 1'b0; av = 1'b1;
      id = 6; res = 64'h66; tick("r033 f1");
      id = 7; res = 64'h77; tick("r033 f2");
      wr = 1'b1; id = 0; res = 64'h88; tick("r033 both");
      av = 1'b0; wr = 1'b0;
      check("r033 usage", 64'(use2), 64'd1);
      check("r033 head", 64'(id2), 64'd7);
      tick("r033 after");

      // usage 1, push id 5 with pop
      av = 1'b1; wr = 1'b1; id = 5; res = 64'h55; br = 1'b1;
      tick("r034 both");
      av = 1'b0; wr = 1'b0;
      check("r034 usage", 64'(use2), 64'd1);
      check("r034 head", 64'(id2), 64'd5);
      tick("r034 after");

      // Flush with a push in the same cycle
      av = 1'b1; id = 4; res = 64'h44; tick("r035 fill");
      flush = 1'b1; id = 2; res = 64'hAA; tick("r035 flush");
      flush = 1'b0; av = 1'b0;
      check("r035 usage", 64'(use2), 64'd0);
      check("r035 valid", 64'(val2), 64'd0);
      check("r035 ready", 64'(rdy2), 64'd1);
      check("r035 d4 usage", 64'(use4), 64'd0);
      tick("r035 after");

      // Asynchronous reset mid-operation
      av = 1'b1; id = 1; res = 64'h1234; tick("r027 p1");
      id = 2; res = 64'h5678; tick("r027 p2");
      av = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      qa.delete();
      qb.delete();
      check_reset_state("r027 async");
      @(posedge clk);
      #1 rst_ni = 1'b1;
      av = 1'b1; id = 6; res = 64'h9999; tick("r027 first push");
      av = 1'b0;
      check("r027 push taken", 64'(id2), 64'd6);
      wr = 1'b1; tick("r027 drain");
      tick("r027 drain2");

      // 20 accepted pushes into DEPTH=4 with random writeback ready
      accepted = 0;
      cycles   = 0;
      av = 1'b1;
      while (accepted < 20 && cycles < 400) begin
         res = {$urandom, $urandom};
         br  = 1'($urandom);
         id  = TRANS_ID_BITS'($urandom);
         wr  = 1'($urandom);
         if (qb.size() < 4) accepted++;
         tick("r036 rand");
         cycles++;
      end
      check("r036 accepted", 64'(accepted), 64'd20);
      av = 1'b0; wr = 1'b1;
      repeat (5) tick("r036 drain");
      check("r036 d4 empty", 64'(use4), 64'd0);
      check("r036 d2 empty", 64'(use2), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
